// File: rtl/decode_stage_pipe.sv
// Registered, handshaked RV32I(+M) decode stage: fetch bundle in, control bundle out.
// Optional 2-entry skid buffer keeps in_ready a pure flop output.
module decode_stage_pipe #(
  parameter int PC_W     = 32,
  parameter int ENABLE_M = 1,
  parameter int SKID     = 1,
  parameter int SEQ_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [31:0]       out_instr,
  output logic [4:0]        out_rd,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [2:0]        out_funct3,
  output logic              out_RegWrite,
  output logic              out_ALUSrc,
  output logic              out_MemWrite,
  output logic              out_Branch,
  output logic              out_Jump,
  output logic              out_Jalr,
  output logic [1:0]        out_ResultSrc,
  output logic [1:0]        out_ALUOp,
  output logic [2:0]        out_ImmSrc,
  output logic              out_lui,
  output logic              out_muldiv,
  output logic              out_illegal,
  output logic [SEQ_W-1:0]  out_seq
);

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [31:0]      instr;
    logic             reg_write;
    logic             alu_src;
    logic             mem_write;
    logic             branch;
    logic             jump;
    logic             jalr;
    logic [1:0]       result_src;
    logic [1:0]       alu_op;
    logic [2:0]       imm_src;
    logic             lui;
    logic             muldiv;
    logic             illegal;
    logic [SEQ_W-1:0] seq;
  } bundle_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  // Illegal words keep their decoded selector fields; only state-changing
  // and flow-changing controls are squashed.
  function automatic bundle_t decode_instr(input logic [31:0]      ins,
                                           input logic [PC_W-1:0]  pc,
                                           input logic [SEQ_W-1:0] seq);
    bundle_t b;
    b       = '0;
    b.pc    = pc;
    b.instr = ins;
    b.seq   = seq;
    case (ins[6:0])
      OPC_LOAD: begin
        b.reg_write  = 1'b1;
        b.alu_src    = 1'b1;
        b.result_src = 2'b01;
      end
      OPC_STORE: begin
        b.imm_src   = 3'b001;
        b.alu_src   = 1'b1;
        b.mem_write = 1'b1;
      end
      OPC_OP: begin
        b.reg_write = 1'b1;
        b.alu_op    = 2'b10;
        if (ins[31:25] == 7'b0000001 && ENABLE_M != 0) begin
          b.alu_op = 2'b11;
          b.muldiv = 1'b1;
        end else if (ins[31:25] != 7'b0000000 && ins[31:25] != 7'b0100000) begin
          b.illegal = 1'b1;
        end
      end
      OPC_BRANCH: begin
        b.imm_src = 3'b010;
        b.alu_op  = 2'b01;
        b.branch  = 1'b1;
        b.illegal = (ins[14:13] == 2'b01);
      end
      OPC_OPIMM: begin
        b.reg_write = 1'b1;
        b.alu_src   = 1'b1;
        b.alu_op    = 2'b10;
      end
      OPC_JAL: begin
        b.reg_write  = 1'b1;
        b.imm_src    = 3'b011;
        b.result_src = 2'b10;
        b.jump       = 1'b1;
      end
      OPC_JALR: begin
        b.reg_write  = 1'b1;
        b.alu_src    = 1'b1;
        b.result_src = 2'b10;
        b.jalr       = 1'b1;
        b.illegal    = (ins[14:12] != 3'b000);
      end
      OPC_LUI, OPC_AUIPC: begin
        b.reg_write  = 1'b1;
        b.imm_src    = 3'b100;
        b.alu_src    = 1'b1;
        b.result_src = 2'b11;
        b.lui        = ins[5];
      end
      OPC_FENCE: begin
      end
      default: b.illegal = 1'b1;
    endcase
    if (b.illegal) begin
      b.reg_write = 1'b0;
      b.mem_write = 1'b0;
      b.branch    = 1'b0;
      b.jump      = 1'b0;
      b.jalr      = 1'b0;
      b.muldiv    = 1'b0;
    end
    return b;
  endfunction

  // Stage p0: combinational decode of the presented instruction
  logic [SEQ_W-1:0] seq_p0;
  logic             take_p0;
  bundle_t          dec_p0;
  bundle_t          out_p1;
  logic             vld_p1;

  assign take_p0 = in_valid & in_ready & ~flush;
  assign dec_p0  = decode_instr(in_instr, in_pc, seq_p0);

  always_ff @(posedge clk) begin
    if (!rst_n)       seq_p0 <= '0;
    else if (take_p0) seq_p0 <= seq_p0 + SEQ_W'(1);
  end

  // Stage p1: output register, optionally backed by a skid entry
  generate
    if (SKID != 0) begin : g_skid
      bundle_t skid_p1;
      logic    skid_vld_p1;

      assign in_ready = rst_n & ~skid_vld_p1;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          out_p1      <= '0;
          skid_p1     <= '0;
          vld_p1      <= 1'b0;
          skid_vld_p1 <= 1'b0;
        end else if (flush) begin
          vld_p1      <= 1'b0;
          skid_vld_p1 <= 1'b0;
        end else if (!vld_p1 || out_ready) begin
          // in_ready is low whenever the skid entry is occupied, so a new
          // input and a skid drain never compete for the output slot.
          if (skid_vld_p1) begin
            out_p1      <= skid_p1;
            vld_p1      <= 1'b1;
            skid_vld_p1 <= 1'b0;
          end else begin
            vld_p1 <= take_p0;
            if (take_p0) out_p1 <= dec_p0;
          end
        end else if (take_p0) begin
          skid_p1     <= dec_p0;
          skid_vld_p1 <= 1'b1;
        end
      end
    end else begin : g_noskid
      assign in_ready = rst_n & (out_ready | ~vld_p1);

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          out_p1 <= '0;
          vld_p1 <= 1'b0;
        end else if (flush) begin
          vld_p1 <= 1'b0;
        end else if (take_p0) begin
          out_p1 <= dec_p0;
          vld_p1 <= 1'b1;
        end else if (out_ready) begin
          vld_p1 <= 1'b0;
        end
      end
    end
  endgenerate

  assign out_valid     = vld_p1;
  assign out_pc        = out_p1.pc;
  assign out_instr     = out_p1.instr;
  assign out_rd        = out_p1.instr[11:7];
  assign out_rs1       = out_p1.instr[19:15];
  assign out_rs2       = out_p1.instr[24:20];
  assign out_funct3    = out_p1.instr[14:12];
  assign out_RegWrite  = out_p1.reg_write;
  assign out_ALUSrc    = out_p1.alu_src;
  assign out_MemWrite  = out_p1.mem_write;
  assign out_Branch    = out_p1.branch;
  assign out_Jump      = out_p1.jump;
  assign out_Jalr      = out_p1.jalr;
  assign out_ResultSrc = out_p1.result_src;
  assign out_ALUOp     = out_p1.alu_op;
  assign out_ImmSrc    = out_p1.imm_src;
  assign out_lui       = out_p1.lui;
  assign out_muldiv    = out_p1.muldiv;
  assign out_illegal   = out_p1.illegal;
  assign out_seq       = out_p1.seq;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: instance A (skid, M enabled, 8-bit tag) and
// instance B (no skid, M disabled, 2-bit tag) share stimulus; each has its own queue model.
module tb_decode_stage_pipe;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;

  always #5 clk = ~clk;

  logic a_in_ready, a_out_valid, a_rw, a_as, a_mw, a_br, a_j, a_jr, a_lui, a_md, a_ill;
  logic [31:0] a_pc, a_instr;
  logic [4:0]  a_rd, a_rs1, a_rs2;
  logic [2:0]  a_f3, a_imm;
  logic [1:0]  a_rs, a_ao;
  logic [7:0]  a_seq;

  logic b_in_ready, b_out_valid, b_rw, b_as, b_mw, b_br, b_j, b_jr, b_lui, b_md, b_ill;
  logic [31:0] b_pc, b_instr;
  logic [4:0]  b_rd, b_rs1, b_rs2;
  logic [2:0]  b_f3, b_imm;
  logic [1:0]  b_rs, b_ao;
  logic [1:0]  b_seq;

  decode_stage_pipe #(.PC_W(32), .ENABLE_M(1), .SKID(1), .SEQ_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_pc(a_pc), .out_instr(a_instr), .out_rd(a_rd), .out_rs1(a_rs1), .out_rs2(a_rs2),
    .out_funct3(a_f3), .out_RegWrite(a_rw), .out_ALUSrc(a_as), .out_MemWrite(a_mw),
    .out_Branch(a_br), .out_Jump(a_j), .out_Jalr(a_jr), .out_ResultSrc(a_rs),
    .out_ALUOp(a_ao), .out_ImmSrc(a_imm), .out_lui(a_lui), .out_muldiv(a_md),
    .out_illegal(a_ill), .out_seq(a_seq));

  decode_stage_pipe #(.PC_W(32), .ENABLE_M(0), .SKID(0), .SEQ_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_pc(b_pc), .out_instr(b_instr), .out_rd(b_rd), .out_rs1(b_rs1), .out_rs2(b_rs2),
    .out_funct3(b_f3), .out_RegWrite(b_rw), .out_ALUSrc(b_as), .out_MemWrite(b_mw),
    .out_Branch(b_br), .out_Jump(b_j), .out_Jalr(b_jr), .out_ResultSrc(b_rs),
    .out_ALUOp(b_ao), .out_ImmSrc(b_imm), .out_lui(b_lui), .out_muldiv(b_md),
    .out_illegal(b_ill), .out_seq(b_seq));

  logic [105:0] a_obs, b_obs;
  assign a_obs = {a_pc, a_instr, a_rd, a_rs1, a_rs2, a_f3, a_rw, a_as, a_mw, a_br, a_j, a_jr,
                  a_rs, a_ao, a_imm, a_lui, a_md, a_ill, a_seq};
  assign b_obs = {b_pc, b_instr, b_rd, b_rs1, b_rs2, b_f3, b_rw, b_as, b_mw, b_br, b_j, b_jr,
                  b_rs, b_ao, b_imm, b_lui, b_md, b_ill, 6'd0, b_seq};

  int n_vec = 0;
  int n_err = 0;

  // Reference model: per-instance FIFO of expected bundles (front = on the output)
  logic [105:0] mq [2][2];
  int           cnt [2];
  int           seq [2];
  bit           exp_rdy [2];

  task automatic chk(input string tag, input logic [105:0] obs, input logic [105:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Control word from the opcode table: {RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, ALUOp}
  function automatic logic [105:0] model(input logic [31:0] w, input logic [31:0] pc,
                                         input bit enm, input int s);
    logic [9:0] c;
    bit br, j, jr, lui, md, ill;
    logic [6:0] f7;
    logic [2:0] f3;
    c = '0; br = 0; j = 0; jr = 0; lui = 0; md = 0; ill = 0;
    f7 = w[31:25];
    f3 = w[14:12];
    case (w[6:0])
      7'h03: c = 10'b1_000_1_0_01_00;
      7'h23: c = 10'b0_001_1_1_00_00;
      7'h33: begin
        c = 10'b1_000_0_0_00_10;
        if (f7 == 7'h01 && enm) begin c[1:0] = 2'b11; md = 1; end
        else if (!(f7 == 7'h00 || f7 == 7'h20)) ill = 1;
      end
      7'h63: begin c = 10'b0_010_0_0_00_01; br = 1; ill = (f3 == 3'd2 || f3 == 3'd3); end
      7'h13: c = 10'b1_000_1_0_00_10;
      7'h6f: begin c = 10'b1_011_0_0_10_00; j = 1; end
      7'h67: begin c = 10'b1_000_1_0_10_00; jr = 1; ill = (f3 != 3'd0); end
      7'h37: begin c = 10'b1_100_1_0_11_00; lui = 1; end
      7'h17: c = 10'b1_100_1_0_11_00;
      7'h0f: c = '0;
      default: ill = 1;
    endcase
    if (ill) begin c[9] = 0; c[4] = 0; br = 0; j = 0; jr = 0; md = 0; end
    return {pc, w, w[11:7], w[19:15], w[24:20], f3, c[9], c[5], c[4], br, j, jr,
            c[3:2], c[1:0], c[8:6], lui, md, ill, 8'(s)};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  ops [10];
    int k;
    ops = '{7'h03, 7'h23, 7'h33, 7'h63, 7'h13, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h0f};
    w = $urandom;
    k = $urandom_range(0, 11);
    if (k < 10) w[6:0] = ops[k];
    if (w[6:0] == 7'h33) begin
      case ($urandom_range(0, 3))
        0: w[31:25] = 7'h00;
        1: w[31:25] = 7'h20;
        2: w[31:25] = 7'h01;
        default: ;
      endcase
    end
    return w;
  endfunction

  task automatic model_cycle(input int d);
    if (!rst_n) begin
      cnt[d] = 0;
      seq[d] = 0;
    end else if (flush) begin
      cnt[d] = 0;
    end else begin
      if (cnt[d] > 0 && out_ready) begin
        mq[d][0] = mq[d][1];
        cnt[d]--;
      end
      if (in_valid && exp_rdy[d]) begin
        mq[d][cnt[d]] = model(in_instr, in_pc, d == 0, seq[d]);
        cnt[d]++;
        seq[d] = (seq[d] + 1) % (d == 0 ? 256 : 4);
      end
    end
  endtask

  // One clock: check in_ready mid-cycle, advance model at the edge, check outputs after it
  task automatic step();
    bit was_rst;
    @(negedge clk);
    exp_rdy[0] = rst_n && (cnt[0] < 2);
    exp_rdy[1] = rst_n && (out_ready || cnt[1] == 0);
    chk("a_in_ready", 106'(a_in_ready), 106'(exp_rdy[0]));
    chk("b_in_ready", 106'(b_in_ready), 106'(exp_rdy[1]));
    @(posedge clk);
    was_rst = !rst_n;
    model_cycle(0);
    model_cycle(1);
    #1;
    chk("a_out_valid", 106'(a_out_valid), 106'(cnt[0] > 0));
    chk("b_out_valid", 106'(b_out_valid), 106'(cnt[1] > 0));
    if (was_rst) begin
      chk("a_reset_bundle", a_obs, '0);
      chk("b_reset_bundle", b_obs, '0);
    end
    if (cnt[0] > 0) chk("a_bundle", a_obs, mq[0][0]);
    if (cnt[1] > 0) chk("b_bundle", b_obs, mq[1][0]);
  endtask

  task automatic drive(input bit v, input logic [31:0] w, input bit rdy, input bit fl);
    in_valid  = v;
    in_instr  = w;
    in_pc     = in_pc + 32'd4;
    out_ready = rdy;
    flush     = fl;
  endtask

  logic [31:0] stream [8];
  logic [31:0] bad [3];
  logic [9:0]  seq_got;

  initial begin
    cnt = '{0, 0};
    seq = '{0, 0};
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = 32'h0000_1000;
    step();
    step();

    // addi x1,x0,10
    rst_n = 1'b1;
    drive(1, 32'h00A00093, 1, 0);
    step();
    chk("addi_ctrl", 106'({a_out_valid, a_rw, a_as, a_imm, a_ao, a_rd, a_seq, a_ill}),
        106'({1'b1, 1'b1, 1'b1, 3'b000, 2'b10, 5'd1, 8'd0, 1'b0}));

    // lw sw beq jal jalr lui auipc mul back-to-back
    stream = '{32'h0000A103, 32'h0020A023, 32'h00208463, 32'h008000EF,
               32'h000080E7, 32'h123452B7, 32'h00001317, 32'h02208033};
    for (int i = 0; i < 8; i++) begin
      drive(1, stream[i], 1, 0);
      step();
    end
    chk("a_mul", 106'({a_ao, a_md, a_ill}), 106'({2'b11, 1'b1, 1'b0}));
    chk("b_mul_no_m", 106'({b_rw, b_ill, b_md}), 106'({1'b0, 1'b1, 1'b0}));

    // illegal words
    bad = '{32'h00000000, 32'h0020A463, 32'h000090E7};
    for (int i = 0; i < 3; i++) begin
      drive(1, bad[i], 1, 0);
      step();
      chk("illegal_ctrl", 106'({a_ill, a_rw, a_mw, a_br, a_j, a_jr, a_md}), 106'(7'b1000000));
    end

    // stall with input pressure: skid fills, then drains in order
    drive(0, 32'h0, 1, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1, rand_instr(), 0, 0);
      step();
    end
    chk("a_skid_full", 106'({a_out_valid, a_in_ready}), 106'(2'b10));
    for (int i = 0; i < 3; i++) begin
      drive(0, 32'h0, 1, 0);
      step();
    end

    // flush with output valid, skid full and an input presented
    for (int i = 0; i < 2; i++) begin
      drive(1, rand_instr(), 0, 0);
      step();
    end
    drive(1, rand_instr(), 0, 1);
    step();
    chk("flush_state", 106'({a_out_valid, a_in_ready, b_out_valid, b_in_ready}), 106'(4'b0101));
    drive(1, 32'h00500113, 1, 0);
    step();

    // reset mid-stream, then tag wrap on the 2-bit instance
    drive(1, rand_instr(), 1, 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    seq_got = '0;
    for (int i = 0; i < 5; i++) begin
      drive(1, rand_instr(), 1, 0);
      step();
      seq_got = {seq_got[7:0], b_seq};
    end
    chk("b_seq_wrap", 106'(seq_got), 106'({2'd0, 2'd1, 2'd2, 2'd3, 2'd0}));

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 3) != 0,
            $urandom_range(0, 29) == 0);
      in_pc = $urandom;
      rst_n = (i != 300);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/decode_stage_pipe.md
Name: decode_stage_pipe

Overview:
- Registered, handshaked RV32I instruction decode stage for the pipelined core; successor to the single-cycle main decoder.
- Accepts {pc, instr} on a valid/ready input and emits a registered control bundle plus register indices on a valid/ready output.
- Adds optional M-extension decode, illegal-instruction detection, a 3-bit immediate selector covering U-type, a skid buffer and a wrapping sequence tag.
- Sits between fetch and the register-read/execute stage. Branch condition evaluation moves to execute; this block only flags branches.

Parameters:
- PC_W, 32, program-counter width.
- ENABLE_M, 1, decode the M extension: OP opcode with funct7=0000001 is legal; when 0 it is illegal.
- SKID, 1. 1 = 2-entry skid buffer with registered in_ready. 0 = single output register with in_ready = out_ready | !out_valid.
- SEQ_W, 8, width of the sequence tag.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  PC_W  instruction address.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  downstream accepts bundle.
- out_pc  out  PC_W  registered pc.
- out_instr  out  32  registered instruction.
- out_rd, out_rs1, out_rs2  out  5 each  instr[11:7], [19:15], [24:20].
- out_funct3  out  3  instr[14:12], carries the branch type to execute.
- out_RegWrite, out_ALUSrc, out_MemWrite, out_Branch, out_Jump, out_Jalr  out  1 each  control bits.
- out_ResultSrc  out  2  00 ALU, 01 mem, 10 pc+4, 11 U-imm path.
- out_ALUOp  out  2  00 add, 01 branch compare, 10 funct-decoded, 11 muldiv.
- out_ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
- out_lui  out  1  U-type is LUI (1) or AUIPC (0).
- out_muldiv  out  1  M-extension op.
- out_illegal  out  1  undecodable instruction.
- out_seq  out  SEQ_W  sequence tag.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All out_* registers, out_valid, the skid entry and the seq counter clear to 0.
  - in_ready is forced to 0 combinationally while rst_n=0.
- Decode, in the fields RegWrite/ImmSrc/ALUSrc/MemWrite/ResultSrc/ALUOp/other:
  - 0000011 lw: 1/000/1/0/01/00.
  - 0100011 sw: 0/001/1/1/00/00.
  - 0110011 OP: 1/000/0/0/00/10. With funct7=0000001 and ENABLE_M=1: ALUOp=11, muldiv=1.
  - 1100011 branch: 0/010/0/0/00/01, Branch=1.
  - 0010011 OP-IMM: 1/000/1/0/00/10.
  - 1101111 jal: 1/011/0/0/10/00, Jump=1.
  - 1100111 jalr: 1/000/1/0/10/00, Jalr=1.
  - 0110111 / 0010111 LUI/AUIPC: 1/100/1/0/11/00, lui=instr[5].
  - 0001111 fence: all controls 0, legal.
- Illegal conditions (out_illegal=1):
  - instr[1:0]!=11, or any opcode not listed above.
  - branch with funct3 010/011.
  - jalr with funct3!=000.
  - OP with funct7 outside {0000000, 0100000}, or 0000001 when ENABLE_M=0.
  - When illegal, RegWrite, MemWrite, Branch, Jump, Jalr and muldiv are forced 0. Passthrough fields stay valid.
- Latency: 1 cycle from an input handshake (in_valid & in_ready) to out_valid. Output handshake is out_valid & out_ready.
- out_* bundle holds stable while out_valid & !out_ready.
- SKID=0: in_ready = rst_n & (out_ready | !out_valid).
- SKID=1: in_ready = rst_n & !skid_valid, registered.
  - Input accepted while out_valid & !out_ready is captured into the skid entry.
  - When the output handshakes and skid_valid=1, the skid entry moves to the output the next cycle.
  - Ordering is strictly preserved. With skid empty and out_ready=1 the stage sustains 1 instruction/cycle.
- flush=1: next cycle out_valid=0 and skid_valid=0. An input presented in the flush cycle is discarded, even if handshaked. Reset has priority over flush.
- out_seq: the value of the seq counter captured with each accepted, non-discarded input.
  - The counter increments by 1 per such input and wraps 2^SEQ_W-1 → 0.
  - Flush does not reset it.

Test Plan:
- Reset, then in_valid with 0x00A00093 (addi x1,x0,10), out_ready=1 -> next cycle: out_valid=1, RegWrite=1, ALUSrc=1, ImmSrc=000, ALUOp=10, rd=1, out_seq=0, illegal=0.
- Stream lw/sw/beq/jal/jalr/lui/auipc/mul (0x02208033) back-to-back, out_ready=1 -> one bundle per cycle matching the table. mul gives ALUOp=11, muldiv=1; with ENABLE_M=0 it gives illegal=1, RegWrite=0.
- Illegal words 0x00000000, beq with funct3=010, jalr with funct3=001 -> illegal=1 and all write/flow controls 0.
- SKID=1, out_ready=0 for 3 cycles while in_valid=1 -> exactly 2 instructions held, in_ready=0 from the 2nd accepting cycle. Release out_ready: both emerge in order, seq consecutive, no loss or duplicate.
- flush asserted with out_valid=1, skid full, in_valid=1 -> next cycle out_valid=0, in_ready=1, discarded input gets no seq; the following accepted instruction continues the seq count.
- SEQ_W=2, accept 5 instructions -> out_seq 0,1,2,3,0. Assert rst_n=0 mid-stream for 1 cycle -> out_valid=0, in_ready=0 during reset, seq restarts at 0.
